// File: rtl/switch_pkg.sv
// Shared types and helpers for the N-port switch.
// Imported by the FIFO and the switch top.
package switch_pkg;

  localparam int DROP_CNT_W  = 16;
  localparam int ITEM_ADDR_W = 8;
  localparam int ITEM_DATA_W = 16;

  typedef struct packed {
    logic [ITEM_ADDR_W-1:0] addr;
    logic [ITEM_DATA_W-1:0] data;
  } sw_item_t;

  function automatic int unsigned port_of(
    input logic [31:0] a,
    input int          addr_w,
    input int          port_w
  );
    return (a >> (addr_w - port_w)) & ((32'd1 << port_w) - 32'd1);
  endfunction

endpackage

// File: rtl/switch_fifo.sv
// Per-port egress FIFO: registered storage, no bypass.
// Extra pointer MSB separates full from empty.
module switch_fifo
  import switch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // pointer update; empty fifo ignores pop so push-only applies
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // storage write; contents are don't-care until pointers cover them
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/nport_switch.sv
// N-port address-routed switch: top address bits pick the egress FIFO.
// Full-FIFO policy is backpressure or drop-and-count.
module nport_switch
  import switch_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int NUM_PORTS    = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter bit DROP_ON_FULL = 1'b0
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        vld,
  output logic                        rdy,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_W-1:0]           data,
  output logic [NUM_PORTS-1:0]        out_vld,
  input  logic [NUM_PORTS-1:0]        out_rdy,
  output logic [NUM_PORTS*ADDR_W-1:0] out_addr,
  output logic [NUM_PORTS*DATA_W-1:0] out_data,
  output logic [DROP_CNT_W-1:0]       drop_cnt
);

  localparam int PORT_W = $clog2(NUM_PORTS);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } item_t;

  item_t                 in_item;
  item_t                 heads [NUM_PORTS];
  logic [NUM_PORTS-1:0]  full;
  logic [NUM_PORTS-1:0]  empty;
  logic [NUM_PORTS-1:0]  push;
  logic [NUM_PORTS-1:0]  pop;
  logic [PORT_W-1:0]     tgt;
  logic                  tgt_full;
  logic [DROP_CNT_W-1:0] cnt;

  assign in_item  = '{addr: addr, data: data};
  assign tgt      = PORT_W'(port_of(32'(addr), ADDR_W, PORT_W));
  assign tgt_full = full[tgt];
  assign rdy      = DROP_ON_FULL ? rstn : (rstn && !tgt_full);
  assign pop      = out_rdy & ~empty;
  assign drop_cnt = cnt;

  // one-hot push towards the target fifo
  always_comb begin
    push = '0;
    if (vld && rdy && !tgt_full) push[tgt] = 1'b1;
  end

  // saturating drop counter, only live in drop mode
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (DROP_ON_FULL && vld && tgt_full && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    switch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push[p]),
      .pop   (pop[p]),
      .din   (in_item),
      .full  (full[p]),
      .empty (empty[p]),
      .head  (heads[p])
    );

    assign out_vld[p]                  = !empty[p];
    assign out_addr[p*ADDR_W +: ADDR_W] = heads[p].addr;
    assign out_data[p*DATA_W +: DATA_W] = heads[p].data;
  end

endmodule
